// File: rtl/rsc_termination_encoder_pkg.sv
// Shared definitions for the LTE constituent RSC encoder and its decoder-side models.
//   TAIL_LEN : number of termination beats appended to each frame
//   RSC_MEM  : encoder memory (state bits s1,s2,s3)
//   G0, G1   : feedback / parity generators in octal (13 = 1+D^2+D^3, 15 = 1+D+D^3)
//   fsm_t    : encoder control states, fixed encodings for compatibility with older blocks
package rsc_termination_encoder_pkg;

    localparam int TAIL_LEN = 3;
    localparam int RSC_MEM  = 3;

    localparam logic [3:0] G0 = 4'o13;
    localparam logic [3:0] G1 = 4'o15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } fsm_t;

endpackage

// File: rtl/rsc_termination_encoder_step.sv
// One trellis step of the RSC encoder (purely combinational).
//   u      in  : information bit (ignored when tail=1)
//   s      in  : current state {s1,s2,s3}
//   tail   in  : termination step; input is replaced by the feedback so a=0
//   u_eff  out : bit actually fed to the trellis (systematic output)
//   a      out : feedback node value
//   z      out : parity bit
//   s_next out : next state {a,s1,s2}
module rsc_termination_encoder_step
    import rsc_termination_encoder_pkg::*;
(
    input  logic               u,
    input  logic [RSC_MEM-1:0] s,
    input  logic               tail,
    output logic               u_eff,
    output logic               a,
    output logic               z,
    output logic [RSC_MEM-1:0] s_next
);

    // s[2]=s1, s[1]=s2, s[0]=s3
    assign u_eff  = tail ? (s[1] ^ s[0]) : u;
    assign a      = u_eff ^ s[1] ^ s[0];
    assign z      = a ^ s[2] ^ s[0];
    assign s_next = {a, s[2], s[1]};

endmodule

// File: rtl/rsc_termination_encoder.sv
// Constituent RSC encoder with trellis termination, bit-serial ready/valid on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_bit is the info bit, in_last marks the frame's final bit
//   out_valid/out_ready : output handshake; one register stage between accept and out_*
//   out_sys, out_par    : systematic and parity bit of the beat
//   out_tail, out_last  : beat is a termination beat / the final termination beat
//   frame_len           : info-bit count of the last completed frame (saturates at K_MAX+1)
//   len_err             : one-cycle pulse when the completed frame length is outside [K_MIN,K_MAX]
//
// state | meaning
// IDLE  | waiting for the first info bit of a frame
// DATA  | accepting info bits until in_last
// TAIL  | inputs stalled, emitting TAIL_LEN termination beats
module rsc_termination_encoder
    import rsc_termination_encoder_pkg::*;
#(
    parameter  int K_MAX = 6144,
    parameter  int K_MIN = 40,
    localparam int CW    = $clog2(K_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_bit,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sys,
    output logic          out_par,
    output logic          out_tail,
    output logic          out_last,
    output logic [CW-1:0] frame_len,
    output logic          len_err
);

    localparam logic [CW-1:0] KMIN_C = CW'(K_MIN);
    localparam logic [CW-1:0] KMAX_C = CW'(K_MAX);
    localparam logic [CW-1:0] KSAT_C = CW'(K_MAX + 1);

    fsm_t               fsm;
    logic [1:0]         tail_cnt;
    logic [RSC_MEM-1:0] s_q;
    logic [CW-1:0]      frame_cnt;
    logic [CW-1:0]      frame_cnt_inc;

    logic               advance;
    logic               accept;
    logic               tail_go;
    logic               tail_last;
    logic               step_u_eff;
    logic               step_a;
    logic               step_z;
    logic [RSC_MEM-1:0] step_s_next;

    assign advance   = !out_valid || out_ready;
    // Held low during reset so upstream never sees a handshake on a block being cleared.
    assign in_ready  = rst_n && (fsm != TAIL) && advance;
    assign accept    = in_valid && in_ready;
    assign tail_go   = (fsm == TAIL) && advance;
    assign tail_last = (tail_cnt == 2'(TAIL_LEN - 1));

    assign frame_cnt_inc = (frame_cnt == KSAT_C) ? frame_cnt : frame_cnt + CW'(1);

    rsc_termination_encoder_step u_step (
        .u      (in_bit),
        .s      (s_q),
        .tail   (fsm == TAIL),
        .u_eff  (step_u_eff),
        .a      (step_a),
        .z      (step_z),
        .s_next (step_s_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            tail_cnt <= 2'd0;
        end else begin
            case (fsm)
                IDLE: if (accept) fsm <= in_last ? TAIL : DATA;
                DATA: if (accept && in_last) fsm <= TAIL;
                TAIL: begin
                    if (tail_go) begin
                        if (tail_last) begin
                            fsm      <= IDLE;
                            tail_cnt <= 2'd0;
                        end else begin
                            tail_cnt <= tail_cnt + 2'd1;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '0;
            out_valid <= 1'b0;
            out_sys   <= 1'b0;
            out_par   <= 1'b0;
            out_tail  <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept || tail_go) begin
            s_q       <= step_s_next;
            out_valid <= 1'b1;
            out_sys   <= step_u_eff;
            out_par   <= step_z;
            out_tail  <= tail_go;
            out_last  <= tail_go && tail_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // frame_cnt saturates at K_MAX+1 so oversize frames still report as out of range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            frame_len <= '0;
            len_err   <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (accept) begin
                if (in_last) begin
                    frame_cnt <= '0;
                    frame_len <= frame_cnt_inc;
                    len_err   <= (frame_cnt_inc < KMIN_C) || (frame_cnt_inc > KMAX_C);
                end else begin
                    frame_cnt <= frame_cnt_inc;
                end
            end
        end
    end

    tail_feedback_zero: assert property (@(posedge clk) disable iff (!rst_n)
        tail_go |-> !step_a);

    terminated_state_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (tail_go && tail_last) |=> (s_q == '0));

endmodule

// File: tb/tb_rsc_termination_encoder.sv
module tb_rsc_termination_encoder;

    localparam int K_MAX = 6144;
    localparam int K_MIN = 40;
    localparam int CW    = $clog2(K_MAX + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_bit;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_sys;
    logic          out_par;
    logic          out_tail;
    logic          out_last;
    logic [CW-1:0] frame_len;
    logic          len_err;

    rsc_termination_encoder #(.K_MAX(K_MAX), .K_MIN(K_MIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sys   (out_sys),
        .out_par   (out_par),
        .out_tail  (out_tail),
        .out_last  (out_last),
        .frame_len (frame_len),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] expq[$];     // {sys,par,tail,last}
    logic [3:0] blog[$];
    bit         sb_en = 1'b1;
    bit         rmode = 1'b0;
    int         err_pulses = 0;
    logic       fbits[0:K_MAX];

    typedef struct {
        int         idx;
        logic       u;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent golden model: encode k bits from fbits then three terminating beats.
    function automatic void push_model(input int k);
        logic [2:0] ms;
        logic       u, a, z;
        ms = 3'b000;
        for (int i = 0; i < k; i++) begin
            u  = fbits[i];
            a  = u ^ ms[1] ^ ms[0];
            z  = a ^ ms[2] ^ ms[0];
            expq.push_back({u, z, 1'b0, 1'b0});
            ms = {a, ms[2], ms[1]};
        end
        for (int t = 0; t < 3; t++) begin
            u  = ms[1] ^ ms[0];
            z  = ms[2] ^ ms[0];
            expq.push_back({u, z, 1'b1, (t == 2) ? 1'b1 : 1'b0});
            ms = {1'b0, ms[2], ms[1]};
        end
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pops, hold-stability while stalled, len_err pulse counting.
    initial begin
        logic [3:0] hv;
        logic [3:0] cur;
        logic [3:0] e;
        bit         held;
        held = 1'b0;
        hv   = 4'd0;
        forever begin
            @(negedge clk);
            #1;
            cur = {out_sys, out_par, out_tail, out_last};
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_data", int'(cur), int'(hv));
                end
                if (out_valid && out_ready && sb_en) begin
                    blog.push_back(cur);
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_beat: got beat %b, expected none (t=%0t)", cur, $time);
                    end else begin
                        e = expq.pop_front();
                        chk("beat", int'(cur), int'(e));
                    end
                end
                held = out_valid && !out_ready;
                hv   = cur;
                if (len_err) err_pulses++;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; returns at the negedge after the last accept with in_valid still high.
    task automatic drive_frame(input int k, output int stalls);
        int wait_n;
        push_model(k);
        stalls = 0;
        wait_n = 0;
        for (int i = 0; i < k;) begin
            in_valid = 1'b1;
            in_bit   = fbits[i];
            in_last  = (i == k - 1);
            #1;
            if (in_ready) begin
                i++;
                wait_n = 0;
            end else begin
                stalls++;
                wait_n++;
            end
            @(negedge clk);
            if (wait_n > 100) begin
                total++;
                bad++;
                $display("FAIL in_ready_wait: in_ready low for %0d cycles, expected <= 100", wait_n);
                break;
            end
        end
    endtask

    task automatic drain();
        bit done;
        in_valid = 1'b0;
        in_last  = 1'b0;
        done     = 1'b0;
        for (int n = 0; n < 20000 && !done; n++) begin
            @(negedge clk);
            #2;
            if (expq.size() == 0 && !out_valid) done = 1'b1;
        end
        chk("drain_done", int'(done), 1);
        @(negedge clk);
    endtask

    task automatic rand_bits(input int k);
        for (int i = 0; i < k; i++) fbits[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int st1, st2, base, e0;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
        #3;
        chk("rst_outputs", int'({out_valid, out_sys, out_par, out_tail, out_last, len_err}), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_frame_len", int'(frame_len), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // K=40 all zero
        for (int i = 0; i < 40; i++) fbits[i] = 1'b0;
        base = blog.size();
        e0   = err_pulses;
        drive_frame(40, st1);
        drain();
        chk("t1_beats", blog.size() - base, 43);
        chk("t1_frame_len", int'(frame_len), 40);
        chk("t1_len_err", err_pulses - e0, 0);

        // K=40 impulse; table supplies stimulus and expected beats
        tbl[0] = '{0, 1'b1, 4'b1100};
        tbl[1] = '{1, 1'b0, 4'b0100};
        tbl[2] = '{2, 1'b0, 4'b0100};
        tbl[3] = '{3, 1'b0, 4'b0100};
        tbl[4] = '{4, 1'b0, 4'b0000};
        tbl[5] = '{5, 1'b0, 4'b0000};
        tbl[6] = '{6, 1'b0, 4'b0100};
        tbl[7] = '{40, 1'b0, 4'b0010};
        tbl[8] = '{41, 1'b0, 4'b0110};
        tbl[9] = '{42, 1'b0, 4'b1111};
        for (int i = 0; i < 40; i++) fbits[i] = 1'b0;
        for (int v = 0; v < 10; v++) if (tbl[v].idx < 40) fbits[tbl[v].idx] = tbl[v].u;
        base = blog.size();
        drive_frame(40, st1);
        drain();
        chk("t2_beats", blog.size() - base, 43);
        for (int v = 0; v < 10; v++) begin
            if (base + tbl[v].idx < blog.size())
                chk($sformatf("t2_beat%0d", tbl[v].idx), int'(blog[base + tbl[v].idx]), int'(tbl[v].exp));
            else
                chk($sformatf("t2_beat%0d_present", tbl[v].idx), blog.size() - base, tbl[v].idx + 1);
        end

        // random K=6144 with random backpressure
        rand_bits(6144);
        rmode = 1'b1;
        e0    = err_pulses;
        drive_frame(6144, st1);
        drain();
        rmode = 1'b0;
        @(negedge clk);
        chk("t3_frame_len", int'(frame_len), 6144);
        chk("t3_len_err", err_pulses - e0, 0);

        // back-to-back K=40 then K=41, in_valid held high
        rand_bits(41);
        drive_frame(40, st1);
        rand_bits(41);
        drive_frame(41, st2);
        chk("t4_first_stalls", st1, 0);
        chk("t4_gap_stalls", st2, 3);
        chk("t4_frame_len_2", int'(frame_len), 41);
        drain();

        // K=39: too short but fully encoded and terminated
        rand_bits(39);
        base = blog.size();
        e0   = err_pulses;
        drive_frame(39, st1);
        drain();
        chk("t5_beats", blog.size() - base, 42);
        chk("t5_frame_len", int'(frame_len), 39);
        chk("t5_len_err", err_pulses - e0, 1);

        // K_MAX+1 bits
        rand_bits(K_MAX + 1);
        e0 = err_pulses;
        drive_frame(K_MAX + 1, st1);
        drain();
        chk("t5_over_frame_len", int'(frame_len), K_MAX + 1);
        chk("t5_over_len_err", err_pulses - e0, 1);

        // reset in the middle of a frame
        sb_en = 1'b0;
        rand_bits(40);
        for (int i = 0; i < 40; i++) fbits[i] = 1'b1;
        for (int i = 0; i < 20;) begin
            in_valid = 1'b1;
            in_bit   = fbits[i];
            in_last  = 1'b0;
            #1;
            if (in_ready) i++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", int'({out_valid, out_sys, out_par, out_tail, out_last, len_err}), 0);
        chk("t6_rst_in_ready", int'(in_ready), 0);
        chk("t6_rst_frame_len", int'(frame_len), 0);
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        sb_en = 1'b1;
        @(negedge clk);
        rand_bits(40);
        base = blog.size();
        drive_frame(40, st1);
        drain();
        chk("t6_beats", blog.size() - base, 43);
        chk("t6_frame_len", int'(frame_len), 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
